// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding memory transaction at a time.
// Misaligned accesses fault locally; loads abort after TIMEOUT cycles.
module mem_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req_valid,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic        mem_req_ready,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        resp_valid,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err,
   input  logic        resp_ready
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic [10:0] TO_LIMIT = 11'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic [9:0]  cnt;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] rdata_q;
   logic [4:0]  rd_q;
   logic        we_q;
   logic        err_q;
   logic        misalign;
   logic        cnt_hit;

   assign misalign = (req_addr[2:0] != 3'd0);
   assign cnt_hit  = (({1'b0, cnt} + 11'd1) == TO_LIMIT);

   // Handshake outputs decode straight from the state register.
   assign req_ready     = (state == IDLE);
   assign mem_req_valid = (state == ISSUE);
   assign resp_valid    = (state == RESP);

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign resp_data = rdata_q;
   assign resp_rd   = rd_q;
   assign resp_err  = err_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt = misalign ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (mem_req_ready) begin
               state_nxt = we_q ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid || cnt_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, timeout counter and response payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  we_q    <= req_is_store;
                  rd_q    <= req_rd;
                  rdata_q <= '0;
                  err_q   <= misalign;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  cnt     <= '0;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  rdata_q <= mem_rdata;
                  err_q   <= 1'b0;
               end else begin
                  cnt <= cnt + 10'd1;
                  if (cnt_hit) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            RESP: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles in WAIT before a load is aborted (legal range 1..1023).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  upstream request valid; the address is the 64-bit result from the memory-address ALU.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_is_store, req_addr[63:0], req_wdata[63:0], req_rd[4:0]  inputs  request fields: store flag, byte address, store data, destination register tag.
REQ-007 mem_req_valid, mem_we, mem_addr[63:0], mem_wdata[63:0]  outputs  memory request channel.
REQ-008 mem_req_ready  input  1  memory accepts the request.
REQ-009 mem_rvalid  input  1  and mem_rdata[63:0]  input  64  load return.
REQ-010 resp_valid, resp_data[63:0], resp_rd[4:0], resp_err  outputs  response to writeback.
REQ-011 resp_ready  input  1  writeback accepts the response.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on req_valid=1, capture all request fields into registers; if req_addr[2:0]!=0, go to RESP with resp_err=1 and resp_data=0, with no memory request issued; otherwise go to ISSUE.
REQ-014 ISSUE: mem_req_valid=1; mem_addr, mem_we and mem_wdata SHALL be driven from the captured registers and held stable until mem_req_ready=1.
REQ-015 ISSUE handshake (mem_req_valid & mem_req_ready): a store goes to RESP with resp_err=0 and resp_data=0; a load goes to WAIT with the timeout counter cleared.
REQ-016 WAIT: on mem_rvalid=1, capture mem_rdata into resp_data, set resp_err=0 and go to RESP.
REQ-017 WAIT: the counter increments each cycle without mem_rvalid; when the counter reaches TIMEOUT, go to RESP with resp_err=1 and resp_data=0.
REQ-018 mem_rvalid SHALL be ignored in every state except WAIT.
REQ-019 RESP: resp_valid=1 and resp_rd=captured tag; all response fields SHALL be held stable until resp_ready=1, then return to IDLE.
REQ-020 No same-cycle bypass: a new request SHALL be accepted no earlier than the cycle after RESP completes. Minimum latencies from request acceptance to resp_valid: misaligned 1 cycle; store 2 cycles with mem_req_ready=1; load 3 cycles with rvalid on the first WAIT cycle.
REQ-021 mem_req_valid and resp_valid SHALL be registered (state-decoded) outputs, with no combinational path from any input.
REQ-022 Exactly one transaction SHALL be outstanding at any time.

Reset
REQ-023 When rst_n=0 (asynchronous): state=IDLE; counter=0; req_ready=1; mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0; resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
REQ-024 Reset asserted in any state SHALL abandon the transaction with no response; a late mem_rvalid arriving after reset SHALL be ignored.

Verification
REQ-025 Load: addr=0x1000, rd=5, mem_req_ready=1, rvalid after 2 WAIT cycles with rdata=0xDEADBEEF00000001 -> mem_addr=0x1000, mem_we=0; resp_valid with resp_data=0xDEADBEEF00000001, resp_rd=5, resp_err=0.
REQ-026 Store: addr=0x2008, wdata=0x55, mem_req_ready held 0 for 3 cycles -> mem_req_valid=1, mem_we=1, mem_addr=0x2008, mem_wdata=0x55 stable all 4 cycles; one resp_valid with resp_err=0.
REQ-027 Misaligned: addr=0x1003 load -> no mem_req_valid ever asserted; resp_valid the next cycle with resp_err=1, resp_data=0.
REQ-028 Timeout: TIMEOUT=4, load, mem_rvalid never asserted -> resp_valid with resp_err=1 after 4 WAIT cycles.
REQ-029 Backpressure: resp_ready=0 for 5 cycles with req_valid=1 held -> req_ready=0 and resp fields stable throughout; next request accepted the cycle after resp_ready=1.
REQ-030 Reset mid-WAIT: rst_n pulsed low, then mem_rvalid=1 -> all outputs at reset values, no resp_valid.
